// File: rtl/tbus_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tbus_reader_pkg
// Brief    : Shared types and width helpers for the tri-state bus reader.
// Revision : 1.0 - initial release
// ============================================================================
package tbus_reader_pkg;

  // Reader FSM states, binary encoded
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ENA  = 3'd1,
    ST_HOLD = 3'd2,
    ST_TURN = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Width of a source index (never below one bit)
  function automatic int idx_w(input int n_src);
    return (n_src > 1) ? $clog2(n_src) : 1;
  endfunction

  // Width of the shared settle/turnaround counter: clog2(max(SETTLE,TURN)+1)
  function automatic int cnt_w(input int settle, input int turn);
    int m;
    m = (settle > turn) ? settle : turn;
    return (m + 1 > 1) ? $clog2(m + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tbus_dcnt.sv
`default_nettype none
// ============================================================================
// Module   : tbus_dcnt
// Brief    : Loadable down-counter with zero flag, async active-high reset.
//            Saturates at zero; load has priority over decrement.
// Revision : 1.0 - initial release
// ============================================================================
module tbus_dcnt #(
  parameter int CW = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  // Count register: load, else decrement until zero
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/tbus_reader.sv
`default_nettype none
// ============================================================================
// Module   : tbus_reader
// Brief    : Break-before-make read controller for a shared tri-state bus.
//            Enables each source in turn, lets the bus settle, captures the
//            resolved value and hands it out on a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module tbus_reader
  import tbus_reader_pkg::*;
#(
  parameter  int N_SRC  = 4,
  parameter  int W      = 8,
  parameter  int SETTLE = 1,
  parameter  int TURN   = 1,
  localparam int IDX_W  = idx_w(N_SRC)
) (
  input  logic             C,
  input  logic             R,
  input  logic             start,
  input  logic [W-1:0]     bus_in,
  output logic [N_SRC-1:0] E,
  output logic [W-1:0]     out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W       = cnt_w(SETTLE, TURN);
  localparam logic [CNT_W-1:0] C_SETTLE_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] C_TURN_LD   = CNT_W'((TURN > 0) ? TURN - 1 : 0);
  localparam logic [IDX_W-1:0] C_LAST      = IDX_W'(N_SRC - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             w_zero;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_dec;

  // Counter control: arm SETTLE on entry to ENA, TURN on entry to TURN
  always_comb begin
    w_load     = 1'b0;
    w_load_val = C_SETTLE_LD;
    w_dec      = 1'b0;
    case (r_state)
      ST_IDLE: w_load = start;
      ST_ENA:  w_dec  = !w_zero;
      ST_HOLD: begin
        if (out_ready && (r_idx != C_LAST)) begin
          w_load     = 1'b1;
          w_load_val = (TURN > 0) ? C_TURN_LD : C_SETTLE_LD;
        end
      end
      ST_TURN: begin
        if (w_zero) begin
          w_load = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  tbus_dcnt #(
    .CW(CNT_W)
  ) u_dcnt (
    .i_clk      (C),
    .i_rst      (R),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // Sweep FSM with registered stream/status outputs
  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_ENA;
            r_idx   <= '0;
            busy    <= 1'b1;
          end
        end
        ST_ENA: begin
          // Capture and release the source on the same edge
          if (w_zero) begin
            out_data  <= bus_in;
            out_idx   <= r_idx;
            out_valid <= 1'b1;
            r_state   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (r_idx == C_LAST) begin
              r_state <= ST_DONE;
              done    <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= (TURN > 0) ? ST_TURN : ST_ENA;
            end
          end
        end
        ST_TURN: begin
          if (w_zero) begin
            r_state <= ST_ENA;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // One-hot enable decode from registered state and index only
  always_comb begin
    E = '0;
    for (int i = 0; i < N_SRC; i++) begin
      E[i] = (r_state == ST_ENA) && (r_idx == IDX_W'(i));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tbus_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_tbus_reader
// Brief    : Self-checking bench for tbus_reader (two parameter sets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tbus_reader;

  logic clk = 1'b0;
  logic R   = 1'b1;
  always #5 clk = ~clk;

  // DUT 1: SETTLE=1, TURN=1
  logic       start1 = 1'b0, ready1 = 1'b0;
  logic [3:0] E1;
  logic [7:0] data1, bus1;
  logic [1:0] idx1;
  logic       valid1, busy1, done1;

  // DUT 2: SETTLE=3, TURN=0
  logic       start2 = 1'b0, ready2 = 1'b1;
  logic [3:0] E2;
  logic [7:0] data2, bus2;
  logic [1:0] idx2;
  logic       valid2, busy2, done2;
  int         run2 = 0;

  function automatic logic [7:0] oh_idx(input logic [3:0] e);
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < 4; i++) if (e[i]) r = 8'(i);
    return r;
  endfunction

  // Bus models: DUT1 sees its source value whenever enabled; DUT2 only
  // sees the correct value on the third consecutive enable cycle.
  assign bus1 = (E1 != 4'd0) ? 8'hA0 + oh_idx(E1) : 8'hFF;
  assign bus2 = ((E2 != 4'd0) && (run2 == 2)) ? 8'hB0 + oh_idx(E2) : 8'h55;
  always @(posedge clk) run2 <= (E2 != 4'd0) ? run2 + 1 : 0;

  tbus_reader #(.N_SRC(4), .W(8), .SETTLE(1), .TURN(1)) u_dut1 (
    .C(clk), .R(R), .start(start1), .bus_in(bus1), .E(E1),
    .out_data(data1), .out_idx(idx1), .out_valid(valid1),
    .out_ready(ready1), .busy(busy1), .done(done1)
  );

  tbus_reader #(.N_SRC(4), .W(8), .SETTLE(3), .TURN(0)) u_dut2 (
    .C(clk), .R(R), .start(start2), .bus_in(bus2), .E(E2),
    .out_data(data2), .out_idx(idx2), .out_valid(valid2),
    .out_ready(ready2), .busy(busy2), .done(done2)
  );

  int checks = 0;
  int failures = 0;
  logic [3:0] prevE1 = 4'd0, prevE2 = 4'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Enable invariants for both DUTs, evaluated every sampled cycle
  task automatic inv();
    chk("onehot1", 32'(($countones(E1) > 1) ? 1 : 0), 32'd0);
    chk("onehot2", 32'(($countones(E2) > 1) ? 1 : 0), 32'd0);
    chk("bbm1", 32'(((prevE1 != 0) && (E1 != 0) && (prevE1 != E1)) ? 1 : 0), 32'd0);
    chk("bbm2", 32'(((prevE2 != 0) && (E2 != 0) && (prevE2 != E2)) ? 1 : 0), 32'd0);
    prevE1 = E1;
    prevE2 = E2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    inv();
  endtask

  typedef struct packed {
    logic       st;
    logic       rdy;
    logic [3:0] e;
    logic       v;
    logic [7:0] d;
    logic [1:0] ix;
    logic       b;
    logic       dn;
  } vec_t;

  vec_t tv[48];
  int   nv = 0;

  task automatic add(input logic st, input logic rdy, input logic [3:0] e, input logic v,
                     input logic [7:0] d, input logic [1:0] ix, input logic b, input logic dn);
    tv[nv] = '{st, rdy, e, v, d, ix, b, dn};
    nv++;
  endtask

  initial begin
    int nw, zrun, onrun, seen, got_done;

    // Sweep 1: ready tied high
    add(1,1,4'h1,0,8'h00,0,1,0); add(0,1,4'h0,1,8'hA0,0,1,0); add(0,1,4'h0,0,8'hA0,0,1,0);
    add(0,1,4'h2,0,8'hA0,0,1,0); add(0,1,4'h0,1,8'hA1,1,1,0); add(0,1,4'h0,0,8'hA1,1,1,0);
    add(0,1,4'h4,0,8'hA1,1,1,0); add(0,1,4'h0,1,8'hA2,2,1,0); add(0,1,4'h0,0,8'hA2,2,1,0);
    add(0,1,4'h8,0,8'hA2,2,1,0); add(0,1,4'h0,1,8'hA3,3,1,0); add(0,1,4'h0,0,8'hA3,3,1,1);
    add(0,1,4'h0,0,8'hA3,3,0,0);
    // Sweep 2: backpressure on word 1, stray starts, start held through DONE
    add(1,1,4'h1,0,8'hA3,3,1,0); add(1,1,4'h0,1,8'hA0,0,1,0); add(1,1,4'h0,0,8'hA0,0,1,0);
    add(0,1,4'h2,0,8'hA0,0,1,0); add(0,0,4'h0,1,8'hA1,1,1,0);
    for (int i = 0; i < 5; i++) add(i[0],0,4'h0,1,8'hA1,1,1,0);
    add(0,1,4'h0,0,8'hA1,1,1,0); add(1,1,4'h4,0,8'hA1,1,1,0); add(0,1,4'h0,1,8'hA2,2,1,0);
    add(0,1,4'h0,0,8'hA2,2,1,0); add(0,1,4'h8,0,8'hA2,2,1,0); add(1,1,4'h0,1,8'hA3,3,1,0);
    add(1,1,4'h0,0,8'hA3,3,1,1); add(1,1,4'h0,0,8'hA3,3,0,0); add(1,1,4'h1,0,8'hA3,3,1,0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset1", {E1, valid1, data1, idx1, busy1, done1}, 32'd0);
    chk("reset2", {E2, valid2, busy2, done2}, 32'd0);
    @(negedge clk) R = 1'b0;

    // Table-driven cycle-by-cycle sweeps
    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      start1 = tv[i].st;
      ready1 = tv[i].rdy;
      step();
      chk($sformatf("row%0d", i), {E1, valid1, data1, idx1, busy1, done1},
          {tv[i].e, tv[i].v, tv[i].d, tv[i].ix, tv[i].b, tv[i].dn});
    end

    // Async reset between edges while in ENA: outputs drop before next edge
    #2 R = 1'b1;
    #1;
    chk("arst_ena", {E1, valid1, busy1, data1}, 32'd0);
    @(negedge clk);
    R = 1'b0;
    start1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_after_rst", {E1, valid1, busy1, done1}, 32'd0);
    end

    // Async reset in HOLD drops the pending word
    @(negedge clk) start1 = 1'b1; ready1 = 1'b0;
    step();
    @(negedge clk) start1 = 1'b0;
    step();
    chk("hold_before_rst", {valid1, data1}, {1'b1, 8'hA0});
    #3 R = 1'b1;
    #1;
    chk("arst_hold", {E1, valid1, busy1, data1}, 32'd0);
    @(negedge clk) R = 1'b0;
    prevE1 = 4'd0;
    prevE2 = 4'd0;

    // SETTLE=3, TURN=0 sweep on DUT2
    nw = 0; zrun = 0; onrun = 0; seen = 0; got_done = 0;
    @(negedge clk) start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int c = 0; c < 60 && got_done == 0; c++) begin
      if (E2 != 4'd0) begin
        if (seen != 0 && zrun > 0) chk("gap2", zrun, 1);
        zrun = 0;
        onrun++;
        seen = 1;
      end else begin
        if (onrun > 0) chk("en_len2", onrun, 3);
        onrun = 0;
        if (seen != 0) zrun++;
      end
      if (valid2) begin
        if (nw == 0) chk("first_cap2", c, 3);
        chk("data2", data2, 32'(8'hB0 + 8'(nw)));
        chk("idx2", idx2, 32'(nw & 3));
        nw++;
      end
      if (done2) got_done = 1;
      else step();
    end
    chk("words2", nw, 4);
    chk("done2_seen", got_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
